spi_client_arbiter: RTL and testbench
=====================================

// Module: spi_client_arbiter
// PURPOSE
//  Shares the single SPI master among five config clients: trigger pot, ch1/ch2/ch3 gain pots, and the cal EEPROM.
//  Round-robin arbitration; drives the master's wrt/cmd and the 3-bit ss code (0=trig,1=ch1,2=ch2,3=ch3,4=EEP).
//  Returns the captured read data to the granted client.
//  Sits between dig_core config sequencers and SPI_Master.
// PARAMETERS
//  GAP_CYCLES      4     idle cycles with ss=3'b111 between back-to-back transactions (0 allowed)
//  TIMEOUT_CYCLES  1024  WAIT-state watchdog limit; used only with SPI_ARB_TIMEOUT_EN
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous reset, active-high
//  req           in   5   per-client request level, bit i = client i; held until ack[i]
//  cmd_in        in   80  packed commands; client i at [16*i+15:16*i]
//  ack           out  5   one-hot 1-cycle pulse: client's transaction finished
//  rd_data       out  16  SPI_data_out captured at done; valid in the ack cycle, held until next done
//  busy          out  1   high in any state other than IDLE
//  err           out  1   1-cycle pulse with ack on timeout; constant 0 without macro
//  wrt_SPI       out  1   1-cycle start pulse to SPI master
//  SPI_cmd       out  16  latched command of the granted client
//  SPI_done      in   1   transaction-complete pulse from SPI master
//  SPI_data_out  in   16  shifted-in data from SPI master
//  ss            out  3   encoded slave select; 3'b111 = none selected
// BEHAVIOUR
//  Reset: state=IDLE, ss=3'b111, wrt_SPI=0, ack=0, err=0, busy=0, SPI_cmd=0, rd_data=0, rr_ptr=0.
//  Reset mid-transaction: abort immediately to the reset values; no ack is issued.
//  States: IDLE -> ISSUE -> WAIT -> GAP -> IDLE. All outputs are registered.
//  IDLE: if any req is set, grant the first set bit searching rr_ptr, rr_ptr+1, ... mod 5.
//    At that edge, latch grant index, ss<=index, and SPI_cmd<=cmd_in slice; go to ISSUE.
//  ISSUE: ss is stable for one cycle before the start pulse.
//    wrt_SPI<=1 for exactly one cycle; go to WAIT.
//    Latency: req sampled in cycle 0 -> ss valid in cycle 1 -> wrt_SPI high in cycle 2.
//  WAIT: hold ss and SPI_cmd. When SPI_done is sampled high in cycle k, in cycle k+1:
//    ack[grant]=1, rd_data=SPI_data_out, ss=3'b111, rr_ptr=grant+1 (wraps 4->0).
//    Then go to GAP, or to IDLE if GAP_CYCLES==0.
//  GAP: ss=3'b111 for GAP_CYCLES cycles in total, counting the ack cycle; then IDLE.
//    No grant is made during GAP, so a client drops req after ack without being re-granted.
//  Boundaries:
//    SPI_done outside WAIT is ignored.
//    A client dropping req after grant does not cancel the transaction; ack is still pulsed.
//    Changes to cmd_in after grant are ignored (the command is already latched).
//    Only 5 clients exist; ss codes 5/6 are never driven.
//    Gap counter width is $clog2(GAP_CYCLES+1).
// CONFIGURATION
//  SPI_ARB_TIMEOUT_EN defined:
//    WAIT counts cycles. If TIMEOUT_CYCLES elapse without SPI_done, next cycle:
//    ack[grant]=1, err=1, rd_data=16'hFFFF, ss=3'b111, rr_ptr advances, go to GAP.
//    A counter reset occurs on every entry to WAIT.
//  Not defined: WAIT has no limit, err is tied 0, and no counter is built.
// TESTING
//  1. Only req[4], cmd 16'h0300; SPI_done with data 16'h00A5 -> ss=3'b100 in cycle 1, wrt_SPI in cycle 2,
//     SPI_cmd=16'h0300; ack=5'b10000 and rd_data=16'h00A5 one cycle after done; ss=3'b111.
//  2. req=5'b11111 held, each client re-requesting after its ack -> grants in order 0,1,2,3,4,0;
//     one wrt_SPI per grant; never two acks at once.
//  3. GAP_CYCLES=4, req[1] and req[2] both high -> ss=3'b111 for exactly 4 cycles (including the ack cycle)
//     between the ch1 and ch2 transactions.
//  4. rst pulsed during WAIT -> next cycle ss=3'b111, busy=0, no ack;
//     req[0] then granted first (rr_ptr=0).
//  5. SPI_done pulsed in IDLE and ISSUE -> no ack; state advances normally.
//  6. With SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no SPI_done -> ack and err 17 cycles after WAIT entry,
//     rd_data=16'hFFFF. Without the macro: still in WAIT after 2000 cycles, err=0.

Source files
------------

// File: rtl/spi_client_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : spi_client_arbiter
// Brief    : Round-robin sharing of one SPI master among five config clients
//            (trig pot, ch1/ch2/ch3 gain pots, cal EEPROM). Define
//            SPI_ARB_TIMEOUT_EN to build the WAIT-state watchdog.
// Revision : 1.0 - initial release
//==============================================================================
module spi_client_arbiter #(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  req,
    input  logic [79:0] cmd_in,
    output logic [4:0]  ack,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        err,
    output logic        wrt_SPI,
    output logic [15:0] SPI_cmd,
    input  logic        SPI_done,
    input  logic [15:0] SPI_data_out,
    output logic [2:0]  ss
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_GAP   = 2'd3;

    localparam logic [2:0] c_SS_NONE = 3'b111;
    localparam int         c_GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    // The IDLE cycle that makes the next grant is itself the last deselected
    // cycle, so GAP holds for GAP_CYCLES-1 cycles (ack cycle included).
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);

    if (TIMEOUT_CYCLES < 1 || GAP_CYCLES < 0) begin : g_bad_params
        $error("spi_client_arbiter: GAP_CYCLES must be >= 0 and TIMEOUT_CYCLES >= 1");
    end

    logic [1:0]         r_state,   w_state_nxt;
    logic [2:0]         r_grant,   w_grant_nxt;
    logic [2:0]         r_rr_ptr,  w_rr_nxt;
    logic [c_GAP_W-1:0] r_gap_cnt, w_gap_nxt;
    logic [2:0]         r_ss,      w_ss_nxt;
    logic [15:0]        r_cmd,     w_cmd_nxt;
    logic               r_wrt,     w_wrt_nxt;
    logic [4:0]         r_ack,     w_ack_nxt;
    logic [15:0]        r_rd_data, w_rd_nxt;
    logic               r_busy;
    logic [7:0]         w_req8;
    logic [2:0]         w_pick;
    logic               w_timeout;

    function automatic logic [2:0] wrap5(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 4'd5) s = s - 4'd5;
        return s[2:0];
    endfunction

    assign w_req8 = {3'b000, req};

    // Walk from rr_ptr+4 down to rr_ptr so the closest requester wins.
    always_comb begin
        w_pick = r_rr_ptr;
        for (int i = 4; i >= 0; i--) begin
            if (w_req8[wrap5(r_rr_ptr, 3'(i))]) w_pick = wrap5(r_rr_ptr, 3'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_gap_nxt   = r_gap_cnt;
        w_ss_nxt    = r_ss;
        w_cmd_nxt   = r_cmd;
        w_wrt_nxt   = 1'b0;
        w_ack_nxt   = 5'b00000;
        w_rd_nxt    = r_rd_data;
        case (r_state)
            c_IDLE: begin
                if (|req) begin
                    w_grant_nxt = w_pick;
                    w_ss_nxt    = w_pick;
                    w_cmd_nxt   = cmd_in[{w_pick, 4'b0000} +: 16];
                    w_state_nxt = c_ISSUE;
                end
            end
            c_ISSUE: begin
                w_wrt_nxt   = 1'b1;
                w_state_nxt = c_WAIT;
            end
            c_WAIT: begin
                if (SPI_done || w_timeout) begin
                    w_ack_nxt = 5'b00001 << r_grant;
                    w_rd_nxt  = SPI_done ? SPI_data_out : 16'hFFFF;
                    w_ss_nxt  = c_SS_NONE;
                    w_rr_nxt  = wrap5(r_grant, 3'd1);
                    if (GAP_CYCLES > 1) begin
                        w_gap_nxt   = c_GAP_W'(1);
                        w_state_nxt = c_GAP;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end
            end
            c_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) w_state_nxt = c_IDLE;
                else                         w_gap_nxt   = r_gap_cnt + c_GAP_W'(1);
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_grant   <= 3'd0;
            r_rr_ptr  <= 3'd0;
            r_gap_cnt <= '0;
            r_ss      <= c_SS_NONE;
            r_cmd     <= 16'h0000;
            r_wrt     <= 1'b0;
            r_ack     <= 5'b00000;
            r_rd_data <= 16'h0000;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_ss      <= w_ss_nxt;
            r_cmd     <= w_cmd_nxt;
            r_wrt     <= w_wrt_nxt;
            r_ack     <= w_ack_nxt;
            r_rd_data <= w_rd_nxt;
            r_busy    <= (w_state_nxt != c_IDLE);
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_err;

    assign w_timeout = (r_state == c_WAIT) && (r_to_cnt == c_TO_LAST);

    // Cleared whenever outside WAIT, so every WAIT entry starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_timeout && !SPI_done;
            if (r_state != c_WAIT)  r_to_cnt <= '0;
            else if (!w_timeout)    r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign ack     = r_ack;
    assign rd_data = r_rd_data;
    assign busy    = r_busy;
    assign wrt_SPI = r_wrt;
    assign SPI_cmd = r_cmd;
    assign ss      = r_ss;

endmodule
`default_nettype wire

// File: tb/tb_spi_client_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_spi_client_arbiter
// Brief    : Directed vector table plus hand sequences for spi_client_arbiter.
// Revision : 1.0 - initial release
//==============================================================================
module tb_spi_client_arbiter;

    logic        clk;
    logic        rst;
    logic [4:0]  req;
    logic [79:0] cmd_in;
    logic [4:0]  ack;
    logic [15:0] rd_data;
    logic        busy;
    logic        err;
    logic        wrt_SPI;
    logic [15:0] SPI_cmd;
    logic        SPI_done;
    logic [15:0] SPI_data_out;
    logic [2:0]  ss;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [79:0] c_CMD_BASE = {16'h0300, 16'h1300, 16'h1200, 16'h1100, 16'h1000};

    spi_client_arbiter #(
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .cmd_in       (cmd_in),
        .ack          (ack),
        .rd_data      (rd_data),
        .busy         (busy),
        .err          (err),
        .wrt_SPI      (wrt_SPI),
        .SPI_cmd      (SPI_cmd),
        .SPI_done     (SPI_done),
        .SPI_data_out (SPI_data_out),
        .ss           (ss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  req;
        logic        done;
        logic [15:0] data;
        logic [2:0]  ss;
        logic        wrt;
        logic [4:0]  ack;
        logic        busy;
        logic [15:0] rd;
        logic [15:0] cmd;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_bound", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_ss_sel();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ss != 3'b111) break;
        end
        chk("sel_bound", {31'd0, ss != 3'b111}, 32'd1);
    endtask

    // Entered at the negedge of the first cycle with ss selected.
    task automatic run_txn(input int g, input logic [15:0] data, input logic [15:0] exp_cmd,
                           input bit count_gap, input bit disturb, input bit drop_ack,
                           output int gap);
        gap = 0;
        chk("grant_cmd", SPI_cmd, exp_cmd);
        @(posedge clk); #1;
        if (disturb) begin
            req[g] = 1'b0;
            cmd_in[16*g +: 16] = 16'hDEAD;
        end
        @(negedge clk);
        chk("wrt_pulse", wrt_SPI, 1);
        @(posedge clk); #1;
        SPI_done = 1'b1;
        SPI_data_out = data;
        @(negedge clk);
        chk("wrt_single", wrt_SPI, 0);
        chk("no_early_ack", ack, 0);
        @(posedge clk); #1;
        SPI_done = 1'b0;
        SPI_data_out = 16'h0000;
        @(negedge clk);
        chk("ack_onehot", ack, 32'd1 << g);
        chk("rd_data", rd_data, data);
        chk("ss_release", ss, 3'b111);
        chk("cmd_held", SPI_cmd, exp_cmd);
        if (drop_ack) begin
            @(posedge clk); #1;
            req[g] = 1'b0;
        end
        if (count_gap) begin
            gap = 1;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (ss != 3'b111) break;
                gap++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   gap;
        int   order[6];
        bit   saw_ack;
        bit   saw_err;
        int   n;

        order = '{0, 1, 2, 3, 4, 0};

        // Cycle-by-cycle vectors: single EEPROM client, then done in IDLE/ISSUE ignored.
        tbl[0]  = '{5'b10000, 1'b0, 16'h0000, 3'd7, 1'b0, 5'b00000, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{5'b10000, 1'b0, 16'h0000, 3'd4, 1'b0, 5'b00000, 1'b1, 16'h0000, 16'h0300};
        tbl[2]  = '{5'b10000, 1'b0, 16'h0000, 3'd4, 1'b1, 5'b00000, 1'b1, 16'h0000, 16'h0300};
        tbl[3]  = '{5'b10000, 1'b0, 16'h0000, 3'd4, 1'b0, 5'b00000, 1'b1, 16'h0000, 16'h0300};
        tbl[4]  = '{5'b10000, 1'b1, 16'h00A5, 3'd4, 1'b0, 5'b00000, 1'b1, 16'h0000, 16'h0300};
        tbl[5]  = '{5'b00000, 1'b0, 16'h0000, 3'd7, 1'b0, 5'b10000, 1'b1, 16'h00A5, 16'h0300};
        tbl[6]  = '{5'b00000, 1'b0, 16'h0000, 3'd7, 1'b0, 5'b00000, 1'b1, 16'h00A5, 16'h0300};
        tbl[7]  = '{5'b00000, 1'b0, 16'h0000, 3'd7, 1'b0, 5'b00000, 1'b1, 16'h00A5, 16'h0300};
        tbl[8]  = '{5'b00000, 1'b0, 16'h0000, 3'd7, 1'b0, 5'b00000, 1'b0, 16'h00A5, 16'h0300};
        tbl[9]  = '{5'b00000, 1'b1, 16'hBEEF, 3'd7, 1'b0, 5'b00000, 1'b0, 16'h00A5, 16'h0300};
        tbl[10] = '{5'b10000, 1'b0, 16'h0000, 3'd7, 1'b0, 5'b00000, 1'b0, 16'h00A5, 16'h0300};
        tbl[11] = '{5'b10000, 1'b1, 16'h5555, 3'd4, 1'b0, 5'b00000, 1'b1, 16'h00A5, 16'h0300};
        tbl[12] = '{5'b10000, 1'b0, 16'h0000, 3'd4, 1'b1, 5'b00000, 1'b1, 16'h00A5, 16'h0300};
        tbl[13] = '{5'b10000, 1'b1, 16'h1234, 3'd4, 1'b0, 5'b00000, 1'b1, 16'h00A5, 16'h0300};
        tbl[14] = '{5'b00000, 1'b0, 16'h0000, 3'd7, 1'b0, 5'b10000, 1'b1, 16'h1234, 16'h0300};

        rst = 1'b1;
        req = 5'b00000;
        cmd_in = c_CMD_BASE;
        SPI_done = 1'b0;
        SPI_data_out = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ss", ss, 3'b111);
        chk("rst_wrt", wrt_SPI, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd", SPI_cmd, 0);
        chk("rst_rd", rd_data, 0);

        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            req = tbl[i].req;
            SPI_done = tbl[i].done;
            SPI_data_out = tbl[i].data;
            @(negedge clk);
            chk($sformatf("vec%0d_ss", i), ss, tbl[i].ss);
            chk($sformatf("vec%0d_wrt", i), wrt_SPI, tbl[i].wrt);
            chk($sformatf("vec%0d_ack", i), ack, tbl[i].ack);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("vec%0d_rd", i), rd_data, tbl[i].rd);
            chk($sformatf("vec%0d_cmd", i), SPI_cmd, tbl[i].cmd);
            chk($sformatf("vec%0d_err", i), err, 0);
        end
        @(posedge clk); #1;
        req = 5'b00000;
        SPI_done = 1'b0;
        SPI_data_out = 16'h0000;

        // All clients requesting continuously: strict rotation with 4-cycle gaps.
        wait_idle();
        @(posedge clk); #1;
        req = 5'b11111;
        wait_ss_sel();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rr_order%0d", k), ss, order[k]);
            run_txn(order[k], 16'(16'hA000 + k), c_CMD_BASE[16*order[k] +: 16],
                    k < 5, 1'b0, 1'b0, gap);
            if (k < 5) chk($sformatf("rr_gap%0d", k), gap, 4);
        end
        @(posedge clk); #1;
        req = 5'b00000;

        // ch1 and ch2 together; ch2 drops req and its cmd changes after grant.
        wait_idle();
        @(posedge clk); #1;
        req = 5'b00110;
        wait_ss_sel();
        chk("pair_first_ch1", ss, 1);
        run_txn(1, 16'h0101, 16'h1100, 1'b1, 1'b0, 1'b1, gap);
        chk("pair_gap", gap, 4);
        chk("pair_then_ch2", ss, 2);
        run_txn(2, 16'h0202, 16'h1200, 1'b0, 1'b1, 1'b0, gap);
        @(posedge clk); #1;
        req = 5'b00000;
        cmd_in = c_CMD_BASE;

        // Reset in WAIT aborts silently and returns rr_ptr to 0.
        wait_idle();
        @(posedge clk); #1;
        req = 5'b01000;
        wait_ss_sel();
        chk("rst_pre_grant3", ss, 3);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        req = 5'b01001;
        @(negedge clk);
        chk("midrst_ss", ss, 3'b111);
        chk("midrst_busy", busy, 0);
        chk("midrst_ack", ack, 0);
        chk("midrst_cmd", SPI_cmd, 0);
        chk("midrst_rd", rd_data, 0);
        wait_ss_sel();
        chk("midrst_rr0", ss, 0);
        run_txn(0, 16'h4242, 16'h1000, 1'b1, 1'b0, 1'b1, gap);
        chk("midrst_gap", gap, 4);
        chk("hang_grant3", ss, 3);
        chk("hang_cmd", SPI_cmd, 16'h1300);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hang_wrt", wrt_SPI, 1);

`ifdef SPI_ARB_TIMEOUT_EN
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            n++;
            if (ack != 5'b00000) break;
        end
        chk("to_latency", n, 17);
        chk("to_ack", ack, 5'b01000);
        chk("to_err", err, 1);
        chk("to_rd", rd_data, 16'hFFFF);
        chk("to_ss", ss, 3'b111);
        @(negedge clk);
        chk("to_err_pulse", err, 0);
        chk("to_ack_pulse", ack, 0);
`else
        saw_ack = 1'b0;
        saw_err = 1'b0;
        n = 0;
        repeat (2000) begin
            @(negedge clk);
            n++;
            if (ack != 5'b00000) saw_ack = 1'b1;
            if (err) saw_err = 1'b1;
        end
        chk("nolimit_ack", {31'd0, saw_ack}, 0);
        chk("nolimit_err", {31'd0, saw_err}, 0);
        chk("nolimit_busy", busy, 1);
        chk("nolimit_ss", ss, 3);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
